wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two sources: the pipeline writeback stage and a long-latency unit (divider / multi-cycle result source).
- Pipeline writeback always has priority and passes through with zero latency.
- Long-latency results are held in a small in-order buffer and drained into idle write-port cycles.
- Also provides a pending-write mask for the decode interlock, squashes WAW-stale results, and raises a stall request when a buffered result starves.

Parameters:
- DEPTH, 2, entries in the long-latency holding buffer (power of 2, range 2 to 8).
- MAX_WAIT, 4, consecutive blocked cycles for the buffer head before stall_req asserts.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- wb_we  in  1  pipeline writeback write enable.
- wb_waddr  in  5  pipeline writeback register address (`RegAddrBus).
- wb_wdata  in  32  pipeline writeback data (`RegBus).
- lu_valid  in  1  long-latency unit result valid.
- lu_waddr  in  5  long-latency result destination register.
- lu_wdata  in  32  long-latency result data.
- lu_ready  out  1  buffer can accept; a transfer occurs when lu_valid && lu_ready.
- we  out  1  write enable to the regfile write port.
- waddr  out  5  write address to the regfile.
- wdata  out  32  write data to the regfile.
- pend_mask  out  32  bit r=1 while a valid buffered entry targets register r.
- stall_req  out  1  request to the pipeline controller to insert a writeback bubble.

Behaviour:
- Reset: while rst==0, the buffer is emptied, the wait counter is cleared, and we/waddr/wdata/pend_mask/stall_req are forced to 0. lu_ready is 0 during reset.
- Buffer structure: circular FIFO with head/tail pointers plus a per-entry valid bit. count = occupied slots, including squashed slots. lu_ready = (count < DEPTH), with no same-cycle pop credit.
- Port selection (combinational, each cycle):
  - If wb_we=1, the write port carries the wb_* values.
  - Else if count>0 and the head is valid, the write port carries the head entry, which is popped at the edge.
  - Else if count>0 and the head is invalid, the head is popped with we=0.
  - Else we=0, waddr=0, wdata=0.
- Latency: WB passes through with 0 cycles. An LU result accepted at edge N reaches the port no earlier than the cycle following edge N.
- Squash (WAW): when wb_we=1 and wb_waddr!=0, every buffered entry with a matching waddr has its valid bit cleared at the edge. An LU result accepted in that same cycle with the same waddr is accepted (lu_ready honoured) but stored invalid, because the LU result is the older instruction.
- Address 0:
  - An LU result with waddr 0 is accepted and stored invalid.
  - A WB write to address 0 passes through unchanged and squashes nothing.
- Simultaneous push and pop in one cycle is legal. Count is unchanged, and each pointer wraps modulo DEPTH.
- pend_mask is the OR over valid entries of the one-hot of each entry's waddr. It is purely combinational from state, so it updates the cycle after a push, pop, or squash.
- Wait counter:
  - Increments when the head is valid and wb_we=1.
  - Clears when the head pops or the buffer is empty.
  - Saturates at MAX_WAIT.
- stall_req = (counter == MAX_WAIT) && head valid. It holds until the head is written.
- Ordering: buffered entries drain strictly in FIFO order. There is no reordering around invalid entries; each invalid entry costs one idle port cycle.

Decomposition:
- Widths come from the shared defines file: `RegBus, `RegAddrBus, `RegNum, `ZeroWord.
- Add to the shared defines: `WbArbDepth and `WbArbMaxWait defaults.
- One natural sub-module: wb_hold_fifo (storage, pointers, valid bits, squash compare, pend_mask). The top level holds the port mux and the wait counter.

Test Plan:
- Reset mid-operation: fill 2 entries, then drive rst=0 for 1 cycle -> next cycle count=0, pend_mask=0, we=0, lu_ready=1 after release.
- WB idle path:
  - Push LU r5=0x1234 at cycle 0 with wb_we=0 -> we=1, waddr=5, wdata=0x1234 in cycle 1.
  - pend_mask[5]=1 in cycle 1 only.
- Priority and full:
  - wb_we=1 for 6 cycles while LU pushes r3 then r4 -> lu_ready=0 after 2 pushes.
  - stall_req=1 after 4 blocked cycles.
  - Once wb_we drops, r3 is written then r4, in order.
- Squash:
  - Buffer r7=0xAAAA, then WB writes r7=0xBBBB -> pend_mask[7]=0 next cycle.
  - The later idle cycle shows we=0, and r7 is never overwritten with 0xAAAA.
- Same-cycle squash: LU push r9 with WB writing r9 in the same cycle -> accepted, stored invalid, no later write to r9.
- Wrap and zero: stream 10 LU results (including waddr 0) with alternating WB activity -> all nonzero addresses are written in order, waddr 0 is never written, and pointers wrap correctly.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file widths plus the types and helpers used by the
// writeback port arbiter and its holding FIFO.
`ifndef WB_ARB_DEFINES
`define WB_ARB_DEFINES
`define RegBus       31:0
`define RegAddrBus   4:0
`define RegNum       32
`define ZeroWord     32'h00000000
`define WbArbDepth   2
`define WbArbMaxWait 4
`endif

package wb_port_arbiter_pkg;

    localparam int REG_W           = 32;
    localparam int ADDR_W          = 5;
    localparam int REG_NUM         = `RegNum;
    localparam logic [`RegBus] ZERO_WORD = `ZeroWord;
    localparam int WB_ARB_DEPTH    = `WbArbDepth;
    localparam int WB_ARB_MAX_WAIT = `WbArbMaxWait;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_HEAD,
        SRC_DROP
    } wb_src_e;

    function automatic logic [REG_NUM-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        logic [REG_NUM-1:0] oh;
        oh    = '0;
        oh[a] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_hold_fifo.sv
// In-order holding buffer for long-latency results: storage, pointers,
// per-entry valid bits, WAW squash and the pending-register mask.
module wb_hold_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_ARB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [ADDR_W-1:0]   push_addr_i,
    input  logic [REG_W-1:0]    push_data_i,
    input  logic                pop_i,
    input  logic                sq_en_i,
    input  logic [ADDR_W-1:0]   sq_addr_i,
    output logic [CNT_W-1:0]    count_o,
    output logic                head_vld_o,
    output logic [ADDR_W-1:0]   head_addr_o,
    output logic [REG_W-1:0]    head_data_o,
    output logic [REG_NUM-1:0]  pend_mask_o
);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [REG_W-1:0]  data_q [DEPTH];
    logic              push_keep;

    // A same-cycle WB write to the same register makes the older LU result dead on arrival.
    assign push_keep = (push_addr_i != '0) && !(sq_en_i && (sq_addr_i == push_addr_i));

    always_comb begin
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (sq_en_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == sq_addr_i) begin
                    vld_d[i] = 1'b0;
                end
            end
        end
        if (pop_i) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (push_i) begin
            vld_d[tail_q] = push_keep;
            tail_d        = tail_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend_mask_o = pend_mask_o | addr_onehot(addr_q[i]);
            end
        end
    end

    assign count_o     = count_q;
    assign head_vld_o  = vld_q[head_q];
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback passes straight through,
// buffered long-latency results drain into idle cycles, starvation raises stall_req.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = WB_ARB_DEPTH,
    parameter int MAX_WAIT = WB_ARB_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [4:0]    wb_waddr,
    input  logic [31:0]   wb_wdata,
    input  logic          lu_valid,
    input  logic [4:0]    lu_waddr,
    input  logic [31:0]   lu_wdata,
    output logic          lu_ready,
    output logic          we,
    output logic [4:0]    waddr,
    output logic [31:0]   wdata,
    output logic [31:0]   pend_mask,
    output logic          stall_req
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0]   count;
    logic               head_vld;
    logic [ADDR_W-1:0]  head_addr;
    logic [REG_W-1:0]   head_data;
    logic [REG_NUM-1:0] fifo_mask;
    logic               not_empty;
    logic               push;
    logic               pop;
    logic               sq_en;
    wb_src_e            src;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    assign not_empty = (count != '0);
    assign lu_ready  = rst && (count < CNT_W'(DEPTH));
    assign push      = lu_valid && lu_ready;
    assign sq_en     = wb_we && (wb_waddr != '0);
    assign pop       = (src == SRC_HEAD) || (src == SRC_DROP);

    wb_hold_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (lu_waddr),
        .push_data_i (lu_wdata),
        .pop_i       (pop),
        .sq_en_i     (sq_en),
        .sq_addr_i   (wb_waddr),
        .count_o     (count),
        .head_vld_o  (head_vld),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .pend_mask_o (fifo_mask)
    );

    always_comb begin
        src = SRC_NONE;
        if (wb_we) begin
            src = SRC_WB;
        end else if (not_empty) begin
            src = head_vld ? SRC_HEAD : SRC_DROP;
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = ZERO_WORD;
        if (rst) begin
            case (src)
                SRC_WB: begin
                    we    = 1'b1;
                    waddr = wb_waddr;
                    wdata = wb_wdata;
                end
                SRC_HEAD: begin
                    we    = 1'b1;
                    waddr = head_addr;
                    wdata = head_data;
                end
                default: ;
            endcase
        end
    end

    // Counts only cycles where a live head result is blocked by writeback.
    always_comb begin
        wait_d = wait_q;
        if (!not_empty || pop) begin
            wait_d = '0;
        end else if (head_vld && wb_we && (wait_q != WAIT_W'(MAX_WAIT))) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign pend_mask = rst ? fifo_mask : '0;
    assign stall_req = rst && (wait_q == WAIT_W'(MAX_WAIT)) && not_empty && head_vld;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected LU writes are queued at issue
// time and a negedge monitor checks every write-port cycle against them.
module tb_wb_port_arbiter;

    typedef struct {
        logic        vld;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pend_mask;
    logic        stall_req;

    int   errors    = 0;
    int   checks    = 0;
    int   lu_writes = 0;
    logic mon_en    = 1'b0;
    exp_t lu_q[$];

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .lu_valid  (lu_valid),
        .lu_waddr  (lu_waddr),
        .lu_wdata  (lu_wdata),
        .lu_ready  (lu_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .pend_mask (pend_mask),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        wb_we    = w;
        wb_waddr = wa;
        wb_wdata = wd;
        lu_valid = lv;
        lu_waddr = la;
        lu_wdata = ld;
    endtask

    // Called at a negedge: records the handshake, then updates expectations at the edge.
    task automatic adv(output logic rdy);
        rdy = lu_ready;
        @(posedge clk);
        if (!rst) begin
            lu_q.delete();
        end else begin
            if (wb_we && wb_waddr != 5'd0) begin
                foreach (lu_q[i]) begin
                    if (lu_q[i].addr == wb_waddr) lu_q[i].vld = 1'b0;
                end
            end
            if (lu_valid && rdy) begin
                lu_q.push_back('{vld: (lu_waddr != 5'd0) && !(wb_we && wb_waddr == lu_waddr),
                                 addr: lu_waddr, data: lu_wdata});
            end
        end
        #1;
    endtask

    task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
        logic r;
        drive(w, wa, wd, lv, la, ld);
        @(negedge clk);
        adv(r);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst) begin
            if (wb_we) begin
                chk("wb_pass_we", 32'(we), 32'd1);
                chk("wb_pass_addr", 32'(waddr), 32'(wb_waddr));
                chk("wb_pass_data", wdata, wb_wdata);
            end else if (we) begin
                while (lu_q.size() > 0 && !lu_q[0].vld) void'(lu_q.pop_front());
                if (lu_q.size() == 0) begin
                    chk("lu_unexpected_write", 32'(waddr), 32'hFFFF_FFFF);
                end else begin
                    e = lu_q.pop_front();
                    lu_writes++;
                    chk("lu_drain_addr", 32'(waddr), 32'(e.addr));
                    chk("lu_drain_data", wdata, e.data);
                end
            end
        end
    end

    initial begin
        logic       r;
        int         i;
        int         n;
        int         live;
        logic [4:0] wrap_addr [10];
        wrap_addr = '{5'd12, 5'd0, 5'd13, 5'd14, 5'd0, 5'd15, 5'd16, 5'd17, 5'd0, 5'd18};

        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        mon_en = 1'b1;

        // Idle path: r5 pushed in cycle 0 appears on the port in cycle 1.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
        @(negedge clk);
        chk("idle_ready", 32'(lu_ready), 32'd1);
        chk("idle_pend_c0", pend_mask, 32'd0);
        adv(r);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("idle_we", 32'(we), 32'd1);
        chk("idle_waddr", 32'(waddr), 32'd5);
        chk("idle_wdata", wdata, 32'h0000_1234);
        chk("idle_pend_c1", pend_mask, 32'h0000_0020);
        adv(r);
        @(negedge clk);
        chk("idle_pend_c2", pend_mask, 32'd0);
        chk("idle_we_c2", 32'(we), 32'd0);
        adv(r);

        // Priority: six WB cycles block r3/r4, buffer fills, stall after four blocked cycles.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 5'd1, 32'hC000_0000 + 32'(c), c < 2,
                  (c == 0) ? 5'd3 : 5'd4, (c == 0) ? 32'h0000_0033 : 32'h0000_0044);
            @(negedge clk);
            if (c == 1) chk("prio_ready_c1", 32'(lu_ready), 32'd1);
            if (c == 2) chk("prio_full_ready", 32'(lu_ready), 32'd0);
            if (c == 2) chk("prio_pend", pend_mask, 32'h0000_0018);
            if (c == 4) chk("prio_stall_c4", 32'(stall_req), 32'd0);
            if (c == 5) chk("prio_stall_c5", 32'(stall_req), 32'd1);
            adv(r);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("prio_first_r3", 32'(waddr), 32'd3);
        chk("prio_stall_hold", 32'(stall_req), 32'd1);
        adv(r);
        @(negedge clk);
        chk("prio_second_r4", 32'(waddr), 32'd4);
        chk("prio_stall_clear", 32'(stall_req), 32'd0);
        adv(r);
        @(negedge clk);
        chk("prio_empty_we", 32'(we), 32'd0);
        adv(r);

        // Squash of a buffered entry by a later WB to the same register.
        cyc(1'b1, 5'd2, 32'hD000_0000, 1'b1, 5'd7, 32'h0000_AAAA);
        drive(1'b1, 5'd7, 32'h0000_BBBB, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("sq_pend_before", pend_mask, 32'h0000_0080);
        adv(r);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("sq_pend_after", pend_mask, 32'd0);
        chk("sq_idle_we", 32'(we), 32'd0);
        adv(r);
        @(negedge clk);
        chk("sq_idle_we2", 32'(we), 32'd0);
        adv(r);

        // Same-cycle squash: LU r9 arrives while WB writes r9.
        drive(1'b1, 5'd9, 32'h0000_9999, 1'b1, 5'd9, 32'h0000_5555);
        @(negedge clk);
        chk("same_ready", 32'(lu_ready), 32'd1);
        adv(r);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("same_we", 32'(we), 32'd0);
        chk("same_pend", pend_mask, 32'd0);
        adv(r);
        @(negedge clk);
        chk("same_we2", 32'(we), 32'd0);
        adv(r);

        // Reset mid-operation with two live entries buffered.
        cyc(1'b1, 5'd1, 32'hE000_0000, 1'b1, 5'd10, 32'h0000_0010);
        cyc(1'b1, 5'd1, 32'hE000_0001, 1'b1, 5'd11, 32'h0000_0011);
        drive(1'b1, 5'd1, 32'hE000_0002, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("mr_pend_full", pend_mask, 32'h0000_0C00);
        chk("mr_ready_full", 32'(lu_ready), 32'd0);
        adv(r);
        rst = 1'b0;
        drive(1'b1, 5'd1, 32'hE000_0003, 1'b1, 5'd12, 32'h0000_0012);
        @(negedge clk);
        chk("mr_rst_we", 32'(we), 32'd0);
        chk("mr_rst_pend", pend_mask, 32'd0);
        chk("mr_rst_ready", 32'(lu_ready), 32'd0);
        adv(r);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("mr_post_pend", pend_mask, 32'd0);
        chk("mr_post_we", 32'(we), 32'd0);
        chk("mr_post_ready", 32'(lu_ready), 32'd1);
        chk("mr_post_stall", 32'(stall_req), 32'd0);
        adv(r);

        // Stream ten results, three to r0, against alternating WB traffic.
        i = 0;
        n = 0;
        while (i < 10 && n < 200) begin
            drive(n[0], (n % 4 == 1) ? 5'd0 : 5'd1, 32'hF000_0000 + 32'(n),
                  1'b1, wrap_addr[i], 32'hA000_0000 + 32'(i));
            @(negedge clk);
            adv(r);
            if (r) i++;
            n++;
        end
        chk("wrap_all_accepted", 32'(i), 32'd10);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        live = 0;
        foreach (lu_q[k]) if (lu_q[k].vld) live++;
        chk("drain_left", 32'(live), 32'd0);
        chk("drain_pend", pend_mask, 32'd0);
        chk("lu_write_count", 32'(lu_writes), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
